// File: rtl/fetch_fd_stage.sv
// Fetch stage and FD pipeline register: owns the PC, runs the instruction-memory
// handshake, and applies stall, redirect and halt rules to the FD register.
module fetch_fd_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] pc,
  output logic [15:0] FD_instr,
  output logic [15:0] FD_pc_inc,
  output logic        FD_valid,
  output logic        fetch_halted
);

  typedef enum logic [1:0] {StFetch, StWait, StDiscard, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] fd_instr_q, fd_instr_d;
  logic [15:0] fd_pc_inc_q, fd_pc_inc_d;
  logic        fd_valid_q, fd_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_inc_q, skid_pc_inc_d;
  logic [15:0] target_q, target_d;

  logic [15:0] pc_plus2;
  logic        capture;
  logic        is_halt;

  assign pc_plus2 = pc_q + 16'd2;
  assign is_halt  = (imem_data[15:11] == 5'b00000);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fd_instr_d    = fd_instr_q;
    fd_pc_inc_d   = fd_pc_inc_q;
    fd_valid_d    = fd_valid_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_inc_d = skid_pc_inc_q;
    target_d      = target_q;
    imem_rd       = 1'b0;
    imem_addr     = pc_q;
    capture       = 1'b0;

    unique case (state_q)
      StFetch: begin
        // No request is opened in a redirect cycle, so a flush never orphans a miss.
        imem_rd = !stall && !skid_valid_q && !redirect;
        capture = imem_rd && imem_done;
        if (imem_rd && !imem_done) begin
          state_d = StWait;
        end
      end
      StWait: begin
        imem_rd = 1'b1;
        capture = imem_done;
        if (imem_done) begin
          state_d = StFetch;
        end
      end
      StDiscard: begin
        imem_rd = 1'b1;
        if (imem_done) begin
          state_d = StFetch;
          pc_d    = target_q;
        end
      end
      StHalted: begin
        imem_rd = 1'b0;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (capture) begin
      pc_d = pc_plus2;
      if (is_halt) begin
        state_d = StHalted;
      end
      if (stall) begin
        skid_valid_d  = 1'b1;
        skid_instr_d  = imem_data;
        skid_pc_inc_d = pc_plus2;
      end else begin
        fd_instr_d  = imem_data;
        fd_pc_inc_d = pc_plus2;
        fd_valid_d  = 1'b1;
      end
    end else if (!stall) begin
      if (skid_valid_q) begin
        fd_instr_d   = skid_instr_q;
        fd_pc_inc_d  = skid_pc_inc_q;
        fd_valid_d   = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        fd_instr_d = NOP_INSTR;
        fd_valid_d = 1'b0;
      end
    end

    if (redirect) begin
      fd_instr_d   = NOP_INSTR;
      fd_pc_inc_d  = fd_pc_inc_q;
      fd_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      // An outstanding miss must still complete; park the target until it does.
      if ((state_q == StWait || state_q == StDiscard) && !imem_done) begin
        state_d  = StDiscard;
        target_d = redirect_pc;
        pc_d     = pc_q;
      end else begin
        state_d = StFetch;
        pc_d    = redirect_pc;
      end
    end

    if (rst) begin
      imem_rd = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      fd_instr_q    <= NOP_INSTR;
      fd_pc_inc_q   <= 16'h0000;
      fd_valid_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= NOP_INSTR;
      skid_pc_inc_q <= 16'h0000;
      target_q      <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fd_instr_q    <= fd_instr_d;
      fd_pc_inc_q   <= fd_pc_inc_d;
      fd_valid_q    <= fd_valid_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_inc_q <= skid_pc_inc_d;
      target_q      <= target_d;
    end
  end

  assign pc           = pc_q;
  assign FD_instr     = fd_instr_q;
  assign FD_pc_inc    = fd_pc_inc_q;
  assign FD_valid     = fd_valid_q;
  assign fetch_halted = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_fd_stage.sv
// Bench for fetch_fd_stage: directed scenarios plus a randomized run checked against
// an in-order instruction-stream scoreboard with a random-latency memory.
module tb_fetch_fd_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] NOP      = 16'h0800;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_done, imem_rd, fd_valid, fetch_halted;
  logic [15:0] redirect_pc, imem_data, imem_addr, pc, fd_instr, fd_pc_inc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_fd_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_done   (imem_done),
    .pc          (pc),
    .FD_instr    (fd_instr),
    .FD_pc_inc   (fd_pc_inc),
    .FD_valid    (fd_valid),
    .fetch_halted(fetch_halted)
  );

  // Memory contents: never a HALT encoding (bit 11 forced high).
  function automatic logic [15:0] instr_of(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'h9E37;
    return (m ^ 16'h5A5A) | 16'h0800;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_done = 1'b0; imem_data = 16'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic goto_pc(input logic [15:0] a);
    redirect = 1'b1; redirect_pc = a; imem_done = 1'b0;
    step();
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_done = 1'b0; imem_data = 16'h0;
    #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", imem_rd); end
    step();
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
    checks++; if (fd_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", fd_instr, NOP); end
    checks++; if (fd_pc_inc !== 16'h0) begin errors++; $display("FAIL reset_pc_inc: got %h expected 0000", fd_pc_inc); end
    checks++; if (fd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", fd_valid); end
    checks++; if (fetch_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", fetch_halted); end
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd_held: got %b expected 0", imem_rd); end
    rst = 1'b0;
  endtask

  task automatic test_hits();
    do_reset();
    imem_done = 1'b1; imem_data = 16'h4101;
    #1;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL hit_req0: got rd=%b addr=%h expected rd=1 addr=0000", imem_rd, imem_addr); end
    step();
    checks++; if (fd_instr !== 16'h4101 || fd_pc_inc !== 16'h0002 || fd_valid !== 1'b1) begin errors++; $display("FAIL hit_fd0: got %h/%h/%b expected 4101/0002/1", fd_instr, fd_pc_inc, fd_valid); end
    imem_data = 16'h4202;
    #1;
    checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL hit_req1: got addr=%h expected 0002", imem_addr); end
    step();
    checks++; if (fd_instr !== 16'h4202 || fd_pc_inc !== 16'h0004 || pc !== 16'h0004) begin errors++; $display("FAIL hit_fd1: got %h/%h pc=%h expected 4202/0004 pc=0004", fd_instr, fd_pc_inc, pc); end
    imem_done = 1'b0;
  endtask

  task automatic test_miss();
    do_reset();
    goto_pc(16'h0010);
    for (int i = 0; i < 3; i++) begin
      imem_done = (i == 2);
      imem_data = (i == 2) ? 16'h6123 : 16'hDEAD;
      #1;
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0010) begin errors++; $display("FAIL miss_req%0d: got rd=%b addr=%h expected rd=1 addr=0010", i, imem_rd, imem_addr); end
      step();
      if (i < 2) begin
        checks++; if (fd_instr !== NOP || fd_valid !== 1'b0) begin errors++; $display("FAIL miss_bubble%0d: got %h/%b expected %h/0", i, fd_instr, fd_valid, NOP); end
      end
    end
    checks++; if (fd_instr !== 16'h6123 || fd_pc_inc !== 16'h0012 || fd_valid !== 1'b1) begin errors++; $display("FAIL miss_fd: got %h/%h/%b expected 6123/0012/1", fd_instr, fd_pc_inc, fd_valid); end
    imem_done = 1'b0;
  endtask

  task automatic test_stall_skid();
    do_reset();
    goto_pc(16'h0050);
    step();                                  // miss opens, state waits
    stall = 1'b1; imem_done = 1'b1; imem_data = 16'h5A5A;
    #1;
    checks++; if (imem_rd !== 1'b1) begin errors++; $display("FAIL skid_req: got rd=%b expected 1", imem_rd); end
    step();
    checks++; if (fd_instr !== NOP || fd_valid !== 1'b0 || pc !== 16'h0052) begin errors++; $display("FAIL skid_hold0: got %h/%b pc=%h expected %h/0 pc=0052", fd_instr, fd_valid, pc, NOP); end
    imem_done = 1'b0;
    #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL skid_norq0: got rd=%b expected 0", imem_rd); end
    step();
    checks++; if (fd_instr !== NOP || fd_valid !== 1'b0) begin errors++; $display("FAIL skid_hold1: got %h/%b expected %h/0", fd_instr, fd_valid, NOP); end
    stall = 1'b0;
    #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL skid_norq1: got rd=%b expected 0", imem_rd); end
    step();
    checks++; if (fd_instr !== 16'h5A5A || fd_pc_inc !== 16'h0052 || fd_valid !== 1'b1) begin errors++; $display("FAIL skid_drain: got %h/%h/%b expected 5A5A/0052/1", fd_instr, fd_pc_inc, fd_valid); end
    imem_done = 1'b1; imem_data = 16'h1234;
    #1;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0052) begin errors++; $display("FAIL skid_resume: got rd=%b addr=%h expected rd=1 addr=0052", imem_rd, imem_addr); end
    step();
    checks++; if (fd_instr !== 16'h1234 || fd_pc_inc !== 16'h0054) begin errors++; $display("FAIL skid_next: got %h/%h expected 1234/0054", fd_instr, fd_pc_inc); end
    imem_done = 1'b0;
  endtask

  task automatic test_redirect_discard();
    do_reset();
    goto_pc(16'h0020);
    step();                                  // miss at 0x0020
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    checks++; if (fd_instr !== NOP || fd_valid !== 1'b0) begin errors++; $display("FAIL disc_flush: got %h/%b expected %h/0", fd_instr, fd_valid, NOP); end
    for (int i = 0; i < 2; i++) begin
      imem_done = (i == 1); imem_data = 16'h7777;
      #1;
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0020) begin errors++; $display("FAIL disc_req%0d: got rd=%b addr=%h expected rd=1 addr=0020", i, imem_rd, imem_addr); end
      step();
      checks++; if (fd_instr !== NOP || fd_valid !== 1'b0) begin errors++; $display("FAIL disc_drop%0d: got %h/%b expected %h/0", i, fd_instr, fd_valid, NOP); end
    end
    imem_done = 1'b1; imem_data = 16'h3100;
    #1;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0100) begin errors++; $display("FAIL disc_target: got rd=%b addr=%h expected rd=1 addr=0100", imem_rd, imem_addr); end
    step();
    checks++; if (fd_instr !== 16'h3100 || fd_pc_inc !== 16'h0102) begin errors++; $display("FAIL disc_fd: got %h/%h expected 3100/0102", fd_instr, fd_pc_inc); end
    imem_done = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    goto_pc(16'h0030);
    imem_done = 1'b1; imem_data = 16'h0000;
    step();
    checks++; if (fd_instr !== 16'h0000 || fd_valid !== 1'b1 || fetch_halted !== 1'b1 || pc !== 16'h0032) begin errors++; $display("FAIL halt_enter: got %h/%b halted=%b pc=%h expected 0000/1 halted=1 pc=0032", fd_instr, fd_valid, fetch_halted, pc); end
    imem_done = 1'b0;
    #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL halt_rd: got rd=%b expected 0", imem_rd); end
    step();
    checks++; if (fetch_halted !== 1'b1 || pc !== 16'h0032 || imem_rd !== 1'b0) begin errors++; $display("FAIL halt_stay: got halted=%b pc=%h rd=%b expected 1/0032/0", fetch_halted, pc, imem_rd); end
    goto_pc(16'h0040);
    checks++; if (fetch_halted !== 1'b0 || pc !== 16'h0040) begin errors++; $display("FAIL halt_resume: got halted=%b pc=%h expected 0/0040", fetch_halted, pc); end
    imem_done = 1'b1; imem_data = 16'h2040;
    #1;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL halt_req: got rd=%b addr=%h expected rd=1 addr=0040", imem_rd, imem_addr); end
    step();
    checks++; if (fd_instr !== 16'h2040 || fd_pc_inc !== 16'h0042) begin errors++; $display("FAIL halt_fd: got %h/%h expected 2040/0042", fd_instr, fd_pc_inc); end
    imem_done = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    goto_pc(16'hFFFE);
    imem_done = 1'b1; imem_data = 16'h1111;
    step();
    checks++; if (fd_pc_inc !== 16'h0000 || pc !== 16'h0000) begin errors++; $display("FAIL wrap_inc: got pc_inc=%h pc=%h expected 0000/0000", fd_pc_inc, pc); end
    imem_data = 16'h2222;
    #1;
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h expected 0000", imem_addr); end
    step();
    imem_done = 1'b0;
    step();                                  // miss at 0x0002
    rst = 1'b1;
    #1;
    checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL rst_wait_rd: got rd=%b expected 0", imem_rd); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (imem_rd !== 1'b1 || imem_addr !== RESET_PC || fd_instr !== NOP || fd_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_req: got rd=%b addr=%h fd=%h/%b expected 1/%h fd=%h/0", imem_rd, imem_addr, fd_instr, fd_valid, RESET_PC, NOP); end
    imem_done = 1'b1; imem_data = 16'h3333;
    step();
    checks++; if (fd_instr !== 16'h3333 || fd_pc_inc !== RESET_PC + 16'd2) begin errors++; $display("FAIL rst_wait_fd: got %h/%h expected 3333/%h", fd_instr, fd_pc_inc, RESET_PC + 16'd2); end
    imem_done = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] exp_pc, req_addr, prev_rpc, snap_instr, snap_inc;
    logic        busy, snap_valid, prev_stall, prev_redirect;
    int          remaining, delivered;
    do_reset();
    exp_pc = RESET_PC; busy = 1'b0; delivered = 0; remaining = 0; req_addr = 16'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 99) < 4);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      #1;
      if (imem_rd) begin
        if (!busy) begin
          busy = 1'b1; req_addr = imem_addr; remaining = $urandom_range(0, 3);
        end else begin
          checks++; if (imem_addr !== req_addr) begin errors++; $display("FAIL rnd_addr_stable: got %h expected %h", imem_addr, req_addr); end
        end
        imem_done = (remaining == 0);
        imem_data = imem_done ? instr_of(req_addr) : 16'($urandom);
        if (imem_done) busy = 1'b0;
        else remaining--;
      end else begin
        checks++; if (busy) begin errors++; $display("FAIL rnd_req_dropped: got rd=0 expected 1 addr=%h", req_addr); end
        imem_done = 1'b0; imem_data = 16'($urandom);
      end
      prev_stall = stall; prev_redirect = redirect; prev_rpc = redirect_pc;
      snap_instr = fd_instr; snap_inc = fd_pc_inc; snap_valid = fd_valid;
      step();
      checks++;
      if (prev_redirect) begin
        if (fd_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush: got valid=%b expected 0", fd_valid); end
        exp_pc = prev_rpc;
      end else if (prev_stall) begin
        if (fd_instr !== snap_instr || fd_pc_inc !== snap_inc || fd_valid !== snap_valid) begin
          errors++; $display("FAIL rnd_stall_hold: got %h/%h/%b expected %h/%h/%b", fd_instr, fd_pc_inc, fd_valid, snap_instr, snap_inc, snap_valid);
        end
      end else if (fd_valid) begin
        if (fd_instr !== instr_of(exp_pc) || fd_pc_inc !== exp_pc + 16'd2) begin
          errors++; $display("FAIL rnd_stream: got %h/%h expected %h/%h", fd_instr, fd_pc_inc, instr_of(exp_pc), exp_pc + 16'd2);
        end
        exp_pc = exp_pc + 16'd2;
        delivered++;
      end
    end
    stall = 1'b0; redirect = 1'b0; imem_done = 1'b0;
    checks++; if (delivered < 200) begin errors++; $display("FAIL rnd_progress: got %0d instructions expected at least 200", delivered); end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_stall_skid();
    test_redirect_discard();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_fd_stage.md
Name: fetch_fd_stage

Overview:
- Fetch stage plus FD pipeline register of the 5-stage WISC pipeline.
- Sits directly upstream of the DX pipeline register and produces FD_instr and FD_pc_inc.
- Owns the PC and drives the instruction-memory request handshake, which may take multiple cycles.
- Applies stall, flush/redirect and halt rules, inserting NOPs into FD where required.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0800, encoding placed in FD on reset, flush or bubble. Not 0x0000, which is HALT.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high
stall  in  1  hazard-unit stall; hold PC and FD contents
redirect  in  1  branch/jump resolved taken in X; flush FD, load redirect_pc
redirect_pc  in  16  redirect target
imem_rd  out  1  instruction-memory read request
imem_addr  out  16  request address
imem_data  in  16  returned instruction; valid only when imem_done=1
imem_done  in  1  request complete (same cycle on hit, later on miss)
pc  out  16  current fetch PC
FD_instr  out  16  instruction to decode
FD_pc_inc  out  16  PC+2 of FD_instr
FD_valid  out  1  FD holds a real instruction
fetch_halted  out  1  fetch stopped after a HALT

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, FD_instr=NOP_INSTR, FD_pc_inc=0, FD_valid=0, state=FETCH, skid buffer empty, fetch_halted=0. imem_rd=0 in the reset cycle. Reset mid-miss drops the outstanding request; the first request after reset is to RESET_PC.
- States:
  - FETCH: imem_rd=!stall, imem_addr=pc.
    - imem_done same cycle: capture instruction.
    - No imem_done: go to WAIT.
  - WAIT: imem_rd=1, imem_addr held at the request PC. Stay until imem_done.
  - DISCARD: a redirect occurred during WAIT. Keep imem_rd=1 at the old address until imem_done, drop the data, then go to FETCH with pc=saved target.
  - HALTED: imem_rd=0, fetch_halted=1. Leave only on redirect or rst.
- Capture on imem_done (FETCH or WAIT):
  - !stall: FD_instr<=imem_data, FD_pc_inc<=pc+2, FD_valid<=1, pc<=pc+2.
  - stall: write the data into a 1-entry skid buffer (instr and pc+2); FD holds; pc<=pc+2.
- Skid buffer: while full, no new request issues. On the first cycle with !stall, the buffer moves into FD and empties. When FD advances without a new capture, FD_instr=NOP_INSTR and FD_valid=0 (bubble).
- Stall: FD registers hold their value. PC advances only on a capture.
- Redirect has highest priority; it overrides stall, capture and HALTED:
  - FD_instr<=NOP_INSTR, FD_valid<=0, skid emptied.
  - From WAIT: enter DISCARD and save redirect_pc in a target register.
  - Otherwise: pc<=redirect_pc, state=FETCH.
  - A second redirect while in DISCARD overwrites the saved target.
- Halt: an instruction with bits [15:11]==5'b00000 is latched into FD (or the skid) normally, then state=HALTED and pc holds at HALT+2. A later redirect, from an older branch, resumes fetch.
- Arithmetic: pc+2 is modulo 2^16; 16'hFFFE+2 wraps to 16'h0000.
- Simultaneous stall and imem_done in WAIT: the data goes to the skid buffer and no request is lost.

Test Plan:
- Reset then hits (imem_done same cycle), imem_data=0x4101,0x4202 -> FD_instr=0x4101, FD_pc_inc=2, FD_valid=1; next cycle 0x4202, FD_pc_inc=4; pc=4.
- Miss of 3 cycles at pc=0x0010 -> imem_rd held and imem_addr=0x0010 for all 3 cycles; FD shows NOP/valid=0 until done, then the instruction with FD_pc_inc=0x0012.
- Stall asserted in the completion cycle of a miss returning 0x5A5A, held 2 cycles -> FD unchanged, no new imem_rd; on release FD_instr=0x5A5A, then fetching resumes at +2.
- Redirect to 0x0100 during a miss at 0x0020 -> FD=NOP, old data discarded on done, next imem_addr=0x0100, no instruction from 0x0020 ever reaches FD.
- HALT (0x0000) fetched at 0x0030 -> FD_instr=0x0000, fetch_halted=1, imem_rd=0 thereafter, pc=0x0032; redirect to 0x0040 -> resumes at 0x0040 and fetch_halted=0.
- pc=0xFFFE hit -> FD_pc_inc=0x0000, next imem_addr=0x0000; rst during WAIT -> next request at RESET_PC with FD=NOP.
